// File: rtl/sc_divider_array.sv
// sc_divider_array: multi-lane stochastic divider (JK or CORDIV), optional SC_DIV_WARMUP_EN ready flag
module sc_divider_array #(
  parameter int CHANNELS = 4,
  parameter int DEPTH = 8,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  output logic [CHANNELS-1:0] result,
  output logic                ready
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  logic [7:0] lfsr;
  logic [IW-1:0] idx;
  assign idx = lfsr[IW-1:0];
  // shared history selector, advances on every enabled cycle in either mode
  always_ff @(posedge clk)
    if (rst) lfsr <= SEED_EFF;
    else if (en) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic r;
    logic nxt;
    logic [DEPTH-1:0] hist;
    assign result[i] = r;
    // JK: set/reset/toggle/hold; CORDIV: pass a on b=1, else replay a random history bit
    always_comb nxt = mode ? (b[i] ? a[i] : hist[idx]) : (b[i] ? a[i] & ~r : a[i] | r);
    // lane state; history only shifts on CORDIV pushes
    always_ff @(posedge clk)
      if (rst) begin
        r <= 1'b0;
        hist <= '0;
      end else if (en) begin
        r <= nxt;
        if (mode && b[i]) hist <= {hist[DEPTH-2:0], a[i]};
      end
  end
`ifdef SC_DIV_WARMUP_EN
  localparam logic [IW:0] FULL = (IW+1)'(DEPTH);
  logic [IW:0] cnt;
  logic prev_mode;
  logic have_prev;
  // counts channel-0 pushes since the last mode change, saturating at DEPTH
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      prev_mode <= 1'b0;
      have_prev <= 1'b0;
    end else if (en) begin
      have_prev <= 1'b1;
      prev_mode <= mode;
      cnt <= (have_prev && mode != prev_mode) ? '0 : (mode && b[0] && cnt != FULL) ? cnt + 1'b1 : cnt;
    end
  assign ready = cnt == FULL;
`else
  assign ready = 1'b1;
`endif
endmodule

// File: tb/tb_sc_divider_array.sv
// tb_sc_divider_array: directed and statistical checks of sc_divider_array against a behavioural model
module tb_sc_divider_array;
  logic clk = 1'b0;
  logic rst, en, mode;
  logic [3:0] a, b, result;
  logic ready;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m_lfsr;
  logic [7:0] m_hist [4];
  logic [3:0] m_res;
  logic [7:0] pat;
  logic [3:0] held;
  int ones [4];
  int mism;
  logic [3:0] rb;

  sc_divider_array #(.CHANNELS(4), .DEPTH(8), .SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .result(result), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frac(input string tag, input int cnt);
    n_chk++;
    assert (cnt >= 1926 && cnt <= 2170) else begin
      n_fail++;
      $error("FAIL %s: observed %0d ones expected 1926..2170", tag, cnt);
    end
  endtask

  function automatic logic [3:0] bern(input int num, input int den);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = $urandom_range(den - 1) < num;
    return v;
  endfunction

  task automatic step(input logic e, input logic m, input logic [3:0] av, input logic [3:0] bv);
    logic [2:0] ix;
    en = e; mode = m; a = av; b = bv;
    @(posedge clk);
    #1;
    if (rst) begin
      m_lfsr = 8'hA5;
      m_res = '0;
      for (int c = 0; c < 4; c++) m_hist[c] = '0;
    end else if (e) begin
      ix = m_lfsr[2:0];
      for (int c = 0; c < 4; c++) begin
        if (!m) begin
          case ({av[c], bv[c]})
            2'b01: m_res[c] = 1'b0;
            2'b10: m_res[c] = 1'b1;
            2'b11: m_res[c] = ~m_res[c];
            default: ;
          endcase
        end else if (bv[c]) begin
          m_res[c] = av[c];
          m_hist[c] = {m_hist[c][6:0], av[c]};
        end else m_res[c] = m_hist[c][ix];
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; a = '0; b = '0;
    step(0, 0, 4'h0, 4'h0);
    step(1, 1, 4'hF, 4'hF);
    chk("rst_result", result, 0);
`ifdef SC_DIV_WARMUP_EN
    chk("rst_ready", ready, 0);
`else
    chk("rst_ready", ready, 1);
`endif
    rst = 1'b0;
    step(0, 1, 4'hF, 4'hF);
    chk("idle_result", result, 0);
    step(1, 0, 4'h1, 4'h0);
    chk("jk_set", result[0], 1);
    step(1, 0, 4'h1, 4'h1);
    chk("jk_tog1", result[0], 0);
    step(1, 0, 4'h1, 4'h1);
    chk("jk_tog2", result[0], 1);
    step(1, 0, 4'h1, 4'h1);
    chk("jk_tog3", result[0], 0);
    step(1, 0, 4'h0, 4'h0);
    chk("jk_hold", result[0], 0);
    step(1, 0, 4'h0, 4'h1);
    chk("jk_reset", result[0], 0);
    chk("jk_model", result, m_res);
    mism = 0;
    for (int c = 0; c < 4; c++) ones[c] = 0;
    for (int k = 0; k < 4096; k++) begin
      step(1, 0, bern(1, 4), bern(1, 4));
      if (result !== m_res) mism++;
      for (int c = 0; c < 4; c++) ones[c] += int'(result[c]);
    end
    chk("jk_stat_model", mism, 0);
    for (int c = 0; c < 4; c++) chk_frac($sformatf("jk_frac_ch%0d", c), ones[c]);
    pat = 8'b1000_1101;
    for (int k = 0; k < 8; k++) begin
      step(1, 1, {4{pat[k]}}, 4'hF);
      chk($sformatf("cd_push%0d", k), result[0], pat[k]);
    end
    for (int k = 0; k < 16; k++) begin
      step(1, 1, (k % 2 == 1) ? 4'hF : 4'h0, 4'h0);
      chk($sformatf("cd_replay%0d", k), result, m_res);
    end
    mism = 0;
    for (int c = 0; c < 4; c++) ones[c] = 0;
    for (int k = 0; k < 4096; k++) begin
      rb = bern(4, 5);
      step(1, 1, rb & bern(1, 2), rb);
      if (result !== m_res) mism++;
      for (int c = 0; c < 4; c++) ones[c] += int'(result[c]);
    end
    chk("cd_stat_model", mism, 0);
    for (int c = 0; c < 4; c++) chk_frac($sformatf("cd_frac_ch%0d", c), ones[c]);
    held = result;
    for (int k = 0; k < 10; k++) begin
      step(0, k[0], bern(1, 2), bern(1, 2));
      chk($sformatf("en0_hold%0d", k), result, held);
    end
    for (int k = 0; k < 16; k++) begin
      step(1, 1, 4'h0, 4'h0);
      chk($sformatf("en0_replay%0d", k), result, m_res);
    end
    for (int k = 0; k < 3; k++) step(1, 0, bern(1, 2), bern(1, 2));
    chk("mode_jk", result, m_res);
    step(1, 1, 4'h0, 4'h0);
    chk("mode_stale_hist", result, m_res);
    rst = 1'b1;
    step(1, 1, 4'hF, 4'hF);
    chk("rst_mid_result", result, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 4'hF, 4'h0);
      chk($sformatf("rst_mid_hist%0d", k), result, 0);
    end
`ifdef SC_DIV_WARMUP_EN
    for (int k = 1; k <= 9; k++) begin
      step(1, 1, bern(1, 2), 4'hF);
      chk($sformatf("warm_push%0d", k), ready, (k >= 8) ? 1 : 0);
    end
    step(1, 0, 4'h0, 4'h0);
    chk("warm_mode_drop", ready, 0);
`else
    step(1, 1, 4'h1, 4'hF);
    chk("ready_tied", ready, 1);
    step(1, 0, 4'h0, 4'h0);
    chk("ready_tied_jk", ready, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sc_divider_array.md
Name: sc_divider_array

Overview:
- Multi-channel stochastic-computing divider; successor to the single-channel JK-flip-flop divider.
- Selectable mode per instance run: JK mode (out ≈ pa/(pa+pb), uncorrelated inputs) or CORDIV mode (out ≈ pa/pb, requires a ⊆ b correlated streams).
- CORDIV uses a per-channel history shift register and a shared LFSR for random history selection.
- Sits in the Operations library alongside the other bitstream arithmetic units; consumes and produces unipolar bitstreams, one bit per channel per clock.

Parameters:
CHANNELS, 4, number of independent divider lanes (≥1)
DEPTH, 8, CORDIV history length per channel; power of 2, 2..128
SEED, 8'hA5, LFSR reset value; a SEED of 0 is replaced by 8'h01

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  advance enable; 0 = all state holds
mode  input  1  0 = JK, 1 = CORDIV
a  input  CHANNELS  dividend bitstreams, bit i = channel i
b  input  CHANNELS  divisor bitstreams
result  output  CHANNELS  quotient bitstreams (registered)
ready  output  1  history warm-up complete (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge, has priority over en):
  - result=0
  - all history bits=0
  - LFSR=SEED (or 8'h01)
  - warm-up counter=0
- Latency: result reflects a/b/mode sampled at the previous enabled edge (1 cycle).
- en=0: result, history, LFSR and counter all hold regardless of a/b/mode.
- LFSR, 8 bits, shared by all channels:
  - Advances every enabled cycle in both modes: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Never reaches 0.
  - idx = lfsr[log2(DEPTH)-1:0], taken from the pre-update value.
- JK mode, per channel, on an enabled edge:
  - {a,b}=00: hold
  - {a,b}=01: result<=0
  - {a,b}=10: result<=1
  - {a,b}=11: result<=~result
  - History is untouched in JK mode.
- CORDIV mode, per channel, on an enabled edge:
  - b=1: result<=a and hist<={hist[DEPTH-2:0], a}; hist[0] is the newest bit.
  - b=0: result<=hist[idx]; history unchanged.
  - a=1 with b=0 violates the correlation precondition; no error is raised and the b=0 rule applies (a ignored).
- Mode change mid-stream:
  - No flush; history and result carry over.
  - The first CORDIV cycle after JK uses the stale history.
- Shared idx across channels is intentional (area); output channels are mutually correlated.
- Boundary values:
  - b all-zero stream in CORDIV: result replays history indefinitely (0 after reset).
  - b all-zero stream in JK with a=0: result holds.

Optional Feature:
- Macro: SC_DIV_WARMUP_EN
- Defined:
  - Adds a counter, width log2(DEPTH)+1, saturating at DEPTH.
  - Increments on enabled cycles with mode=1 and b[0]=1 (history pushes of channel 0).
  - Cleared by rst or by any enabled cycle whose mode differs from the previous enabled cycle's mode.
  - ready=1 when counter==DEPTH, otherwise 0; this includes JK mode.
- Undefined: no counter; ready tied to 1 constantly, including during reset.

Test Plan:
1. rst=1 for 2 cycles, then en=0 -> result=0, LFSR=0xA5; ready=0 (macro defined) or 1 (macro undefined).
2. JK, ch0:
   - a=1,b=0 -> result[0]=1 next cycle.
   - Then a=1,b=1 for 3 cycles -> 0,1,0.
   - Then a=0,b=0 -> holds 0.
   - Then a=0,b=1 -> 0.
3. JK statistics: a, b independent Bernoulli p=0.25 on all channels, 4096 enabled cycles -> ones fraction 0.50±0.03 per channel.
4. CORDIV directed:
   - b=all 1s with a[0]=1,0,1,1,0,0,0,1 -> result[0] equals a delayed 1 cycle.
   - Then b=0 for 16 cycles -> result[0] matches a reference model of hist[idx] with LFSR from 0xA5, bit-exact.
5. CORDIV statistics: b p=0.8, a = b & r with r p=0.5 (pa=0.4), 4096 cycles -> ones fraction 0.50±0.03.
6. Control corners:
   - en=0 for 10 cycles mid-stream -> result, history, LFSR unchanged.
   - rst asserted together with en=1 mid-stream -> full reset values next cycle.
   - With macro: ready rises after exactly 8 pushes (DEPTH=8), drops when mode toggles.
